maxpool_mram_arbiter: RTL and testbench
=======================================

MAXPOOL_MRAM_ARBITER -- requirements
Module: maxpool_mram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, MRAM word-address width.
REQ-002 Parameter STARVE_LIMIT, default 8, maximum consecutive writer grants while a read is pending.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 wr_valid  input  1  writer (MaxPool) request.
REQ-006 wr_ready  output  1  writer grant; write accepted when wr_valid && wr_ready.
REQ-007 wr_addr  input  ADDR_W  write word address.
REQ-008 wr_data  input  32  write data.
REQ-009 wr_be  input  4  byte enables.
REQ-010 wr_last  input  1  marks last write of a pooled frame.
REQ-011 rd_valid  input  1  reader (downstream layer) request.
REQ-012 rd_ready  output  1  reader grant; read accepted when rd_valid && rd_ready.
REQ-013 rd_addr  input  32  pixel-index read address, passed through unmodified.
REQ-014 rsp_valid  output  1  read data valid.
REQ-015 rsp_data  output  32  read data.
REQ-016 mram_en_a, mram_we_a[3:0], mram_addr_a[ADDR_W-1:0], mram_din_a[31:0]  output  MRAM port A (write).
REQ-017 mram_en_b  output  1; read_addr  output  32  MRAM port B (read).
REQ-018 mram_dout_b  input  32  MRAM port B data, valid one cycle after mram_en_b.
REQ-019 frame_done  output  1  one-cycle pulse on frame completion.
REQ-020 wr_count  output  ADDR_W+1  writes accepted in current frame.

Function
REQ-021 Grant logic SHALL be combinational from registered state and current requests; at most one of wr_ready, rd_ready SHALL be high per cycle.
REQ-022 Default priority SHALL be writer: both valid and starve counter < STARVE_LIMIT -> wr_ready=1, rd_ready=0.
REQ-023 Starve counter SHALL increment (saturating at STARVE_LIMIT) on each writer grant while rd_valid=1, and SHALL clear on a reader grant or any cycle with rd_valid=0.
REQ-024 When starve counter == STARVE_LIMIT and rd_valid=1, reader SHALL be granted regardless of wr_valid.
REQ-025 A single valid requester SHALL be granted in the same cycle.
REQ-026 Writer grant SHALL drive mram_en_a=1, mram_we_a=wr_be, mram_addr_a=wr_addr, mram_din_a=wr_data combinationally that cycle; otherwise mram_en_a=0, mram_we_a=0.
REQ-027 Reader grant SHALL drive mram_en_b=1, read_addr=rd_addr that cycle; mram_en_a and mram_en_b SHALL never both be 1.
REQ-028 rsp_valid SHALL assert exactly one cycle after each reader grant, with rsp_data=mram_dout_b sampled combinationally in that cycle; back-to-back grants yield back-to-back responses.
REQ-029 Write and read to the same word in consecutive cycles: the read SHALL return the new data (writer granted first).
REQ-030 wr_count SHALL increment per accepted write; on an accepted write with wr_last=1, wr_count SHALL clear to 0 and frame_done SHALL pulse high the next cycle.
REQ-031 wr_count SHALL wrap from 2^ADDR_W to 0 without a frame_done pulse.
REQ-032 FSM states: IDLE (no grant last cycle), WRITE (writer granted last cycle), READ (reader granted last cycle, response pending); READ drives rsp_valid; transitions follow the grant of the current cycle.

Reset
REQ-033 Asserting reset SHALL immediately force wr_ready, rd_ready, rsp_valid, frame_done, mram_en_a, mram_en_b, mram_we_a to 0, and force starve counter, wr_count, FSM (IDLE), mram_addr_a, mram_din_a, read_addr, rsp_data to 0.
REQ-034 A read granted in the cycle before reset assertion SHALL produce no response.
REQ-035 First grant SHALL be possible in the first rising edge after reset deassertion.

Structure
REQ-036 FSM state encoding and STARVE_LIMIT default SHALL live in the shared CNN-engine package.
REQ-037 Grant selection SHALL be one sub-module, mram_grant_sel (requests + starve flag in, one-hot grant out); the rest stays in the top.

Verification
REQ-038 Writes only: 4 writes addr 0..3, data 0xA0..0xA3, wr_be=4'hF -> wr_ready=1 every cycle, mram_en_a pulses match, mram_en_b=0.
REQ-039 Reads only: rd_addr 0,8,16 back-to-back -> rsp_valid 3 consecutive cycles starting one cycle after the first grant, data equals model output.
REQ-040 Contention: wr_valid and rd_valid held high 20 cycles, STARVE_LIMIT=8 -> 8 writer grants, 1 reader grant, repeating; never both enables high.
REQ-041 Frame: 5 writes, last with wr_last=1 -> wr_count 1..4 then 0, frame_done one pulse the cycle after the 5th write.
REQ-042 Reset mid-read: reader granted, reset asserted before the next edge -> rsp_valid stays 0, all outputs 0 while reset=1.
REQ-043 Same-address hazard: write 0x12345678 to word 5, read word 5 next cycle -> rsp_data=0x12345678.

Source files
------------

// File: rtl/maxpool_mram_arbiter_pkg.sv
// Shared CNN-engine definitions used by the MaxPool/MRAM arbiter.
//   StarveLimitDefault : default cap on consecutive writer grants while a read waits
//   arb_state_e        : arbiter FSM encoding (what was granted last cycle)
//   GrantWr / GrantRd  : bit positions inside the one-hot grant vector
package maxpool_mram_arbiter_pkg;

  localparam int unsigned StarveLimitDefault = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWrite = 2'd1,
    StRead  = 2'd2
  } arb_state_e;

  localparam int unsigned GrantWr = 0;
  localparam int unsigned GrantRd = 1;

endpackage

// File: rtl/mram_grant_sel.sv
// Grant selection between the MaxPool writer and the downstream reader.
//   wr_req : writer request (already qualified by reset)
//   rd_req : reader request (already qualified by reset)
//   starve : reader has waited the maximum number of writer grants
//   grant  : one-hot grant, bit GrantWr / GrantRd, all zero when nobody asks
module mram_grant_sel
  import maxpool_mram_arbiter_pkg::*;
(
  input  logic       wr_req,
  input  logic       rd_req,
  input  logic       starve,
  output logic [1:0] grant
);

  // Writer wins ties unless the reader has been starved.
  always_comb begin
    grant = '0;
    if (rd_req && (starve || !wr_req)) begin
      grant[GrantRd] = 1'b1;
    end else if (wr_req) begin
      grant[GrantWr] = 1'b1;
    end
  end

endmodule

// File: rtl/maxpool_mram_arbiter.sv
// Arbitrates a single MRAM between the MaxPool writer (port A) and a downstream
// reader (port B), with a starvation bound for the reader and frame tracking.
//   clk, reset                         : clock, asynchronous active-high reset
//   wr_valid/wr_ready/wr_addr/...      : writer handshake and payload
//   rd_valid/rd_ready/rd_addr          : reader handshake and address
//   rsp_valid/rsp_data                 : read response, one cycle after the grant
//   mram_*_a                           : MRAM write port
//   mram_en_b/read_addr/mram_dout_b    : MRAM read port
//   frame_done                         : pulse the cycle after a wr_last write
//   wr_count                           : writes accepted in the current frame
module maxpool_mram_arbiter
  import maxpool_mram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned STARVE_LIMIT = StarveLimitDefault
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_data,
  input  logic [3:0]        wr_be,
  input  logic              wr_last,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [31:0]       rd_addr,
  output logic              rsp_valid,
  output logic [31:0]       rsp_data,
  output logic              mram_en_a,
  output logic [3:0]        mram_we_a,
  output logic [ADDR_W-1:0] mram_addr_a,
  output logic [31:0]       mram_din_a,
  output logic              mram_en_b,
  output logic [31:0]       read_addr,
  input  logic [31:0]       mram_dout_b,
  output logic              frame_done,
  output logic [ADDR_W:0]   wr_count
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_LIMIT);
  localparam logic [ADDR_W:0] CountMax = {1'b1, {ADDR_W{1'b0}}};

  arb_state_e        state_q, state_d;
  logic [CntW-1:0]   starve_q, starve_d;
  logic [ADDR_W:0]   wr_count_q, wr_count_d;
  logic              frame_done_q, frame_done_d;
  logic [1:0]        grant;
  logic              wr_gnt, rd_gnt;

  // Requests are masked by reset so no grant can leak out while it is held.
  mram_grant_sel u_grant_sel (
    .wr_req (wr_valid && !reset),
    .rd_req (rd_valid && !reset),
    .starve (starve_q == StarveMax),
    .grant  (grant)
  );

  assign wr_gnt = grant[GrantWr];
  assign rd_gnt = grant[GrantRd];

  always_comb begin
    state_d      = StIdle;
    starve_d     = starve_q;
    wr_count_d   = wr_count_q;
    frame_done_d = 1'b0;

    if (wr_gnt) begin
      state_d = StWrite;
    end else if (rd_gnt) begin
      state_d = StRead;
    end

    if (!rd_valid || rd_gnt) begin
      starve_d = '0;
    end else if (wr_gnt && (starve_q != StarveMax)) begin
      starve_d = starve_q + CntW'(1);
    end

    if (wr_gnt) begin
      if (wr_last) begin
        wr_count_d   = '0;
        frame_done_d = 1'b1;
      end else if (wr_count_q == CountMax) begin
        // Silent wrap: overflow is not a frame boundary.
        wr_count_d = '0;
      end else begin
        wr_count_d = wr_count_q + (ADDR_W + 1)'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      starve_q     <= '0;
      wr_count_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      wr_count_q   <= wr_count_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    wr_ready    = wr_gnt;
    rd_ready    = rd_gnt;
    mram_en_a   = wr_gnt;
    mram_we_a   = wr_gnt ? wr_be   : 4'h0;
    mram_addr_a = wr_gnt ? wr_addr : '0;
    mram_din_a  = wr_gnt ? wr_data : 32'h0;
    mram_en_b   = rd_gnt;
    read_addr   = rd_gnt ? rd_addr : 32'h0;
    // Response is the MRAM output in the cycle after the read grant.
    rsp_valid   = (state_q == StRead);
    rsp_data    = rsp_valid ? mram_dout_b : 32'h0;
    frame_done  = frame_done_q;
    wr_count    = wr_count_q;
  end

endmodule

// File: tb/tb_maxpool_mram_arbiter.sv
module tb_maxpool_mram_arbiter;

  localparam int unsigned AW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_valid, wr_ready, wr_last;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic [3:0]    wr_be;
  logic          rd_valid, rd_ready;
  logic [31:0]   rd_addr;
  logic          rsp_valid;
  logic [31:0]   rsp_data;
  logic          mram_en_a;
  logic [3:0]    mram_we_a;
  logic [AW-1:0] mram_addr_a;
  logic [31:0]   mram_din_a;
  logic          mram_en_b;
  logic [31:0]   read_addr;
  logic [31:0]   mram_dout_b;
  logic          frame_done;
  logic [AW:0]   wr_count;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [0:(1<<AW)-1];

  always #5 clk = ~clk;

  maxpool_mram_arbiter #(.ADDR_W(AW), .STARVE_LIMIT(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_be       (wr_be),
    .wr_last     (wr_last),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_addr     (rd_addr),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .mram_en_a   (mram_en_a),
    .mram_we_a   (mram_we_a),
    .mram_addr_a (mram_addr_a),
    .mram_din_a  (mram_din_a),
    .mram_en_b   (mram_en_b),
    .read_addr   (read_addr),
    .mram_dout_b (mram_dout_b),
    .frame_done  (frame_done),
    .wr_count    (wr_count)
  );

  // Synchronous MRAM with byte enables and one-cycle read latency.
  always @(posedge clk) begin
    if (mram_en_a) begin
      for (int b = 0; b < 4; b++) begin
        if (mram_we_a[b]) mem[mram_addr_a][b*8 +: 8] <= mram_din_a[b*8 +: 8];
      end
    end
    if (mram_en_b) mram_dout_b <= mem[read_addr[AW-1:0]];
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs on the falling edge; outputs are sampled 1ns later.
  task automatic drive(input logic wv, input logic [AW-1:0] wa, input logic [31:0] wd,
                       input logic [3:0] wbe, input logic wl, input logic rv,
                       input logic [31:0] ra);
    @(negedge clk);
    wr_valid = wv;
    wr_addr  = wa;
    wr_data  = wd;
    wr_be    = wbe;
    wr_last  = wl;
    rd_valid = rv;
    rd_addr  = ra;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, '0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [31:0] rd_exp [3];
  logic        exp_wr;

  initial begin
    mram_dout_b = 32'h0;
    reset    = 1'b1;
    wr_valid = 1'b1;
    wr_addr  = 10'd3;
    wr_data  = 32'hDEAD_BEEF;
    wr_be    = 4'hF;
    wr_last  = 1'b1;
    rd_valid = 1'b1;
    rd_addr  = 32'd7;

    // Outputs held at zero while reset is asserted, even with both requesting.
    @(negedge clk); #1;
    check_eq("rst_wr_ready", wr_ready, 0);
    check_eq("rst_rd_ready", rd_ready, 0);
    check_eq("rst_en_a", mram_en_a, 0);
    check_eq("rst_en_b", mram_en_b, 0);
    check_eq("rst_addr_a", mram_addr_a, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_wr_count", wr_count, 0);
    check_eq("rst_frame_done", frame_done, 0);
    @(negedge clk);
    reset    = 1'b0;
    wr_valid = 1'b0;
    rd_valid = 1'b0;
    wr_last  = 1'b0;

    // Writes only.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, AW'(i), 32'hA0 + i, 4'hF, 1'b0, 1'b0, 32'h0);
      check_eq("wo_wr_ready", wr_ready, 1);
      check_eq("wo_en_a", mram_en_a, 1);
      check_eq("wo_we_a", mram_we_a, 4'hF);
      check_eq("wo_addr_a", mram_addr_a, i);
      check_eq("wo_din_a", mram_din_a, 32'hA0 + i);
      check_eq("wo_en_b", mram_en_b, 0);
      check_eq("wo_wr_count", wr_count, i);
    end
    idle();
    check_eq("wo_idle_en_a", mram_en_a, 0);
    check_eq("wo_final_count", wr_count, 4);

    // Reads only, after preloading words 8 and 16.
    drive(1'b1, 10'd8, 32'h0000_00B8, 4'hF, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 10'd16, 32'h0000_0B16, 4'hF, 1'b0, 1'b0, 32'h0);
    rd_exp[0] = 32'hA0;
    rd_exp[1] = 32'hB8;
    rd_exp[2] = 32'hB16;
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, '0, 32'h0, 4'h0, 1'b0, 1'b1, 32'(k * 8));
      check_eq("ro_rd_ready", rd_ready, 1);
      check_eq("ro_en_b", mram_en_b, 1);
      check_eq("ro_read_addr", read_addr, k * 8);
      check_eq("ro_en_a", mram_en_a, 0);
      check_eq("ro_rsp_valid", rsp_valid, k > 0);
      if (k > 0) check_eq("ro_rsp_data", rsp_data, rd_exp[k-1]);
    end
    idle();
    check_eq("ro_rsp_valid_last", rsp_valid, 1);
    check_eq("ro_rsp_data_last", rsp_data, rd_exp[2]);
    idle();
    check_eq("ro_rsp_valid_end", rsp_valid, 0);

    // Contention: 8 writer grants then 1 reader grant, repeating.
    for (int c = 0; c < 20; c++) begin
      drive(1'b1, AW'(100 + c), 32'(c), 4'hF, 1'b0, 1'b1, 32'd200);
      exp_wr = (c % 9) != 8;
      check_eq("ct_wr_ready", wr_ready, exp_wr);
      check_eq("ct_rd_ready", rd_ready, !exp_wr);
      check_eq("ct_excl", mram_en_a && mram_en_b, 0);
    end
    idle();
    idle();

    // Frame: 5 writes, the last flagged.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, AW'(i), 32'h50 + i, 4'hF, i == 4, 1'b0, 32'h0);
      check_eq("fr_wr_count", wr_count, i);
      check_eq("fr_done_low", frame_done, 0);
    end
    idle();
    check_eq("fr_count_clr", wr_count, 0);
    check_eq("fr_done_pulse", frame_done, 1);
    idle();
    check_eq("fr_done_once", frame_done, 0);

    // Reset arriving right after a read grant kills the response.
    drive(1'b0, '0, 32'h0, 4'h0, 1'b0, 1'b1, 32'd3);
    check_eq("rr_rd_ready", rd_ready, 1);
    @(posedge clk);
    #2;
    reset    = 1'b1;
    wr_valid = 1'b1;
    wr_addr  = 10'd9;
    wr_data  = 32'h55;
    wr_be    = 4'hF;
    #1;
    check_eq("rr_rsp_valid", rsp_valid, 0);
    check_eq("rr_rsp_data", rsp_data, 0);
    check_eq("rr_wr_ready", wr_ready, 0);
    check_eq("rr_rd_ready0", rd_ready, 0);
    check_eq("rr_en_a", mram_en_a, 0);
    check_eq("rr_en_b", mram_en_b, 0);
    check_eq("rr_we_a", mram_we_a, 0);
    check_eq("rr_addr_a", mram_addr_a, 0);
    check_eq("rr_din_a", mram_din_a, 0);
    check_eq("rr_read_addr", read_addr, 0);
    check_eq("rr_frame_done", frame_done, 0);
    @(negedge clk); #1;
    check_eq("rr_rsp_valid_hold", rsp_valid, 0);
    @(negedge clk);
    reset    = 1'b0;
    rd_valid = 1'b0;
    #1;
    check_eq("rr_first_grant", wr_ready, 1);
    check_eq("rr_rsp_after", rsp_valid, 0);
    idle();
    check_eq("rr_count_after", wr_count, 1);

    // Same-address write then read.
    drive(1'b1, 10'd5, 32'h1234_5678, 4'hF, 1'b0, 1'b0, 32'h0);
    drive(1'b0, '0, 32'h0, 4'h0, 1'b0, 1'b1, 32'd5);
    check_eq("hz_rd_ready", rd_ready, 1);
    idle();
    check_eq("hz_rsp_valid", rsp_valid, 1);
    check_eq("hz_rsp_data", rsp_data, 32'h1234_5678);

    // wr_count reaches 2^ADDR_W then wraps to 0 silently.
    do_reset();
    for (int i = 0; i < (1 << AW); i++) begin
      drive(1'b1, AW'(i), 32'(i), 4'hF, 1'b0, 1'b0, 32'h0);
    end
    idle();
    check_eq("wr_count_max", wr_count, 1 << AW);
    drive(1'b1, 10'd0, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0);
    idle();
    check_eq("wr_count_wrap", wr_count, 0);
    check_eq("wrap_no_done", frame_done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
